fp_add_norm_round: RTL

//  Sequential post-add stage of the single-precision FloatingPointAdder datapath. Takes the raw

---
 rtl/fp_pkg.sv | 21 ++
 rtl/fp_round_rne.sv | 58 +++++
 rtl/fp_add_norm_round.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared constants and state encoding for the single-precision add
// post-normalization/rounding stage.
//   EXP_W/FRAC_W/MW : default field widths (MW = internal mantissa width)
//   EXP_MAX         : all-ones exponent field (Inf/NaN)
//   QNAN_FRAC       : canonical quiet-NaN fraction
//   state_t         : control FSM states
package fp_pkg;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MW     = FRAC_W + 5;

  localparam logic [EXP_W-1:0]  EXP_MAX   = '1;
  localparam logic [FRAC_W-1:0] QNAN_FRAC = {1'b1, {(FRAC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ROUND,
    OUT
  } state_t;
endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even and IEEE-754 packing of a normalized
// (or denormal) mantissa.
//   i_sign    : result sign
//   i_exp     : biased exponent, one extra bit so overflow is visible
//   i_mant    : {hidden, frac[FRAC_W-1:0], G, R, S}
//   i_special : input exponent was all-ones (Inf/NaN pass-through)
//   i_zero    : exact zero sum
//   o_data    : packed {sign, exp, frac}
module fp_round_rne #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic                    i_sign,
  input  logic [EXP_W:0]          i_exp,
  input  logic [FRAC_W+3:0]       i_mant,
  input  logic                    i_special,
  input  logic                    i_zero,
  output logic [EXP_W+FRAC_W:0]   o_data
);
  localparam logic [EXP_W:0]    EXP_INF    = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0]    EXP_INC    = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W-1:0]  EXP_DEN_UP = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [FRAC_W-1:0] QNAN       = {1'b1, {(FRAC_W-1){1'b0}}};

  logic                w_hidden;
  logic                w_inc;
  logic [FRAC_W-1:0]   w_frac;
  logic [FRAC_W+1:0]   w_sum;
  logic [EXP_W:0]      w_exp_rnd;

  always_comb begin
    w_hidden  = i_mant[FRAC_W+3];
    w_frac    = i_mant[FRAC_W+2:3];
    w_inc     = i_mant[2] & (i_mant[1] | i_mant[0] | w_frac[0]);
    // {carry, hidden, frac} after the rounding increment
    w_sum     = {1'b0, w_hidden, w_frac} + {{(FRAC_W+1){1'b0}}, w_inc};
    w_exp_rnd = w_sum[FRAC_W+1] ? i_exp + EXP_INC : i_exp;
    o_data    = '0;

    if (i_special) begin
      o_data = {i_sign, {EXP_W{1'b1}}, (w_frac != '0) ? QNAN : {FRAC_W{1'b0}}};
    end else if (i_zero) begin
      o_data = '0;
    end else if (!w_hidden) begin
      // Denormal: rounding up into the hidden bit makes it the smallest normal
      if (w_sum[FRAC_W]) begin
        o_data = {i_sign, EXP_DEN_UP, w_sum[FRAC_W-1:0]};
      end else begin
        o_data = {i_sign, {EXP_W{1'b0}}, w_sum[FRAC_W-1:0]};
      end
    end else if (w_exp_rnd >= EXP_INF) begin
      o_data = {i_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else begin
      // On carry-out the low fraction bits of w_sum are already zero
      o_data = {i_sign, w_exp_rnd[EXP_W-1:0], w_sum[FRAC_W-1:0]};
    end
  end
endmodule

// File: rtl/fp_add_norm_round.sv
// Sequential post-add stage: normalizes a raw sum one left-shift per cycle,
// rounds to nearest-even and packs an IEEE-754 word.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : raw-sum handshake (ready only when idle)
//   in_sign/in_exp       : sum sign, biased exponent of larger operand
//   in_mant              : {carry, hidden, frac, G, R, S}
//   out_valid/out_ready  : result handshake
//   out_data             : packed {sign, exp, frac}
module fp_add_norm_round #(
  parameter int unsigned EXP_W  = fp_pkg::EXP_W,
  parameter int unsigned FRAC_W = fp_pkg::FRAC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic [FRAC_W+4:0]      in_mant,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+FRAC_W:0]  out_data
);
  import fp_pkg::*;

  localparam int unsigned  MANT_W  = FRAC_W + 5;
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

  state_t                  r_state;
  logic                    r_sign;
  logic                    r_special;
  logic                    r_zero;
  logic                    r_out_valid;
  logic [EXP_W:0]          r_exp;
  // Carry bit is folded away at capture, so only {hidden..S} is kept
  logic [MANT_W-2:0]       r_mant;
  logic [EXP_W+FRAC_W:0]   r_out_data;

  logic [EXP_W:0]          w_in_exp_ext;
  logic [EXP_W:0]          w_exp_dec;
  logic [MANT_W-2:0]       w_mant_shl;
  logic [MANT_W-2:0]       w_carry_mant;
  logic [EXP_W+FRAC_W:0]   w_rounded;

  always_comb begin
    w_in_exp_ext = {1'b0, in_exp};
    w_exp_dec    = r_exp - EXP_ONE;
    w_mant_shl   = {r_mant[MANT_W-3:0], 1'b0};
    // Right shift by one on carry; the dropped bit joins the sticky bit
    w_carry_mant = {in_mant[MANT_W-1:2], in_mant[1] | in_mant[0]};
    in_ready     = (r_state == IDLE);
    out_valid    = r_out_valid;
    out_data     = r_out_data;
  end

  fp_round_rne #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_round (
    .i_sign    (r_sign),
    .i_exp     (r_exp),
    .i_mant    (r_mant),
    .i_special (r_special),
    .i_zero    (r_zero),
    .o_data    (w_rounded)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sign      <= 1'b0;
      r_special   <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_exp       <= '0;
      r_mant      <= '0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign    <= in_sign;
            r_exp     <= w_in_exp_ext;
            r_mant    <= in_mant[MANT_W-2:0];
            r_special <= 1'b0;
            r_zero    <= 1'b0;
            r_state   <= ROUND;
            if (in_exp == '1) begin
              r_special <= 1'b1;
            end else if (in_mant == '0) begin
              r_zero <= 1'b1;
            end else if (in_mant[MANT_W-1]) begin
              r_mant <= w_carry_mant;
              r_exp  <= w_in_exp_ext + EXP_ONE;
            end else if (!in_mant[MANT_W-2] && (w_in_exp_ext > EXP_ONE)) begin
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          // Exit is decided on the post-shift value so every SHIFT cycle shifts
          r_mant <= w_mant_shl;
          r_exp  <= w_exp_dec;
          if (w_mant_shl[MANT_W-2] || (w_exp_dec == EXP_ONE)) begin
            r_state <= ROUND;
          end
        end
        ROUND: begin
          r_out_data  <= w_rounded;
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
